// File: rtl/ddr_rd_burst_sched.sv
// DDR read-burst scheduler for the video read FIFO.
// Walks the frame buffer linearly from FRAME_BASE and issues AXI read-address
// bursts only when the FIFO has guaranteed room for every outstanding beat.
// Returned beats pass straight through to the FIFO write port.
module ddr_rd_burst_sched #(
   parameter int                    ADDR_WIDTH  = 28,
   parameter logic [ADDR_WIDTH-1:0] FRAME_BASE  = {ADDR_WIDTH{1'b0}},
   parameter int                    FRAME_BEATS = 38400,
   parameter int                    BURST_LEN   = 16,
   parameter int                    FIFO_DEPTH  = 1024,
   parameter int                    WL_WIDTH    = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_start,
   input  logic [WL_WIDTH-1:0]   wr_water_level,
   output logic                  axi_arvalid,
   output logic [ADDR_WIDTH-1:0] axi_araddr,
   output logic [7:0]            axi_arlen,
   input  logic                  axi_arready,
   input  logic                  axi_rvalid,
   input  logic [127:0]          axi_rdata,
   input  logic                  axi_rlast,
   output logic                  axi_rready,
   output logic                  fifo_wr_en,
   output logic [127:0]          fifo_wr_data,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  rd_err
);

   // Beat counters are wide enough to also hold BURST_LEN for the min() compare.
   localparam int             CW   = $clog2(FRAME_BEATS + BURST_LEN + 1);
   localparam logic [CW-1:0]  FB_C = CW'(FRAME_BEATS);
   localparam logic [CW-1:0]  BL_C = CW'(BURST_LEN);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      ADDR  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t              state_r, state_next_s;
   logic [CW-1:0]       issued_r, received_r, remain_s, this_len_s;
   logic [WL_WIDTH-1:0] outstanding_r, outstanding_next_s, ar_add_s, r_sub_s;
   logic                restart_pend_r;
   logic                ar_hs_s, r_hs_s, beat_ok_s, space_ok_s;
   logic                clear_ptrs_s, start_ar_s;
   logic [31:0]         need_s;
   logic                unused_rlast_s;

   assign unused_rlast_s = axi_rlast;

   assign remain_s   = FB_C - issued_r;
   assign this_len_s = (remain_s >= BL_C) ? BL_C : remain_s;
   // Credit includes in-flight beats, so a lagging water level only under-reports space.
   assign need_s     = 32'(wr_water_level) + 32'(outstanding_r) + 32'(this_len_s);
   assign space_ok_s = (need_s <= 32'(FIFO_DEPTH));

   assign ar_hs_s   = axi_arvalid & axi_arready;
   assign r_hs_s    = axi_rvalid & axi_rready;
   // A beat arriving with nothing outstanding is an error and is not counted.
   assign beat_ok_s = r_hs_s & (outstanding_r != {WL_WIDTH{1'b0}});

   assign fifo_wr_en   = r_hs_s;
   assign fifo_wr_data = axi_rdata;

   assign ar_add_s = ar_hs_s ? (WL_WIDTH'(axi_arlen) + WL_WIDTH'(1'b1)) : {WL_WIDTH{1'b0}};
   assign r_sub_s  = beat_ok_s ? WL_WIDTH'(1'b1) : {WL_WIDTH{1'b0}};
   assign outstanding_next_s = outstanding_r + ar_add_s - r_sub_s;

   // Next-state logic: decides when to issue, drain, restart or go idle.
   always_comb begin
      state_next_s = state_r;
      clear_ptrs_s = 1'b0;
      start_ar_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (frame_start) begin
               state_next_s = CHECK;
               clear_ptrs_s = 1'b1;
            end else begin
               state_next_s = IDLE;
            end
         end
         CHECK: begin
            if (restart_pend_r || frame_start || (remain_s == {CW{1'b0}})) begin
               state_next_s = DRAIN;
            end else if (space_ok_s) begin
               state_next_s = ADDR;
               start_ar_s   = 1'b1;
            end else begin
               state_next_s = CHECK;
            end
         end
         ADDR: begin
            if (axi_arready) begin
               state_next_s = CHECK;
            end else begin
               state_next_s = ADDR;
            end
         end
         DRAIN: begin
            if (outstanding_r == {WL_WIDTH{1'b0}}) begin
               if (restart_pend_r || frame_start) begin
                  state_next_s = CHECK;
                  clear_ptrs_s = 1'b1;
               end else begin
                  state_next_s = IDLE;
               end
            end else begin
               state_next_s = DRAIN;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State register, beat accounting and the restart request flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r        <= IDLE;
         issued_r       <= {CW{1'b0}};
         received_r     <= {CW{1'b0}};
         outstanding_r  <= {WL_WIDTH{1'b0}};
         restart_pend_r <= 1'b0;
      end else begin
         state_r       <= state_next_s;
         outstanding_r <= outstanding_next_s;
         if (clear_ptrs_s) begin
            issued_r   <= {CW{1'b0}};
            received_r <= {CW{1'b0}};
         end else begin
            if (ar_hs_s) begin
               issued_r <= issued_r + CW'(axi_arlen) + CW'(1'b1);
            end
            if (beat_ok_s) begin
               received_r <= received_r + CW'(1'b1);
            end
         end
         if (clear_ptrs_s) begin
            restart_pend_r <= 1'b0;
         end else if (frame_start && (state_r != IDLE)) begin
            restart_pend_r <= 1'b1;
         end
      end
   end

   // AXI read-address channel: address and length held stable until accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         axi_arvalid <= 1'b0;
         axi_araddr  <= FRAME_BASE;
         axi_arlen   <= 8'd0;
      end else begin
         if (start_ar_s) begin
            axi_arvalid <= 1'b1;
            axi_araddr  <= FRAME_BASE + ADDR_WIDTH'({issued_r, 4'b0000});
            axi_arlen   <= 8'(this_len_s - CW'(1'b1));
         end else if (ar_hs_s) begin
            axi_arvalid <= 1'b0;
         end
      end
   end

   // Status outputs, read-data ready and the sticky protocol error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         axi_rready <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         rd_err     <= 1'b0;
      end else begin
         axi_rready <= (state_next_s != IDLE) || (outstanding_next_s != {WL_WIDTH{1'b0}});
         busy       <= (state_next_s != IDLE);
         frame_done <= beat_ok_s && (received_r == (FB_C - CW'(1'b1))) && !restart_pend_r;
         if (axi_rvalid && (outstanding_r == {WL_WIDTH{1'b0}})) begin
            rd_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ddr_rd_burst_sched.sv
// Scoreboard bench for ddr_rd_burst_sched: directed scenarios push expected
// AR bursts and FIFO beats; a negedge monitor pops and compares them.
module tb_ddr_rd_burst_sched;
   localparam int AW = 28, FB = 40, BL = 16, DEPTH = 1024, WL = 11;

   logic           clk = 1'b0;
   logic           rst, frame_start;
   logic [WL-1:0]  wr_water_level;
   logic           axi_arvalid, axi_arready, axi_rvalid, axi_rlast, axi_rready;
   logic [AW-1:0]  axi_araddr;
   logic [7:0]     axi_arlen;
   logic [127:0]   axi_rdata, fifo_wr_data;
   logic           fifo_wr_en, busy, frame_done, rd_err;

   ddr_rd_burst_sched #(
      .ADDR_WIDTH(AW), .FRAME_BASE(28'h0), .FRAME_BEATS(FB),
      .BURST_LEN(BL), .FIFO_DEPTH(DEPTH), .WL_WIDTH(WL)
   ) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .wr_water_level(wr_water_level),
      .axi_arvalid(axi_arvalid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
      .axi_arready(axi_arready), .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata),
      .axi_rlast(axi_rlast), .axi_rready(axi_rready), .fifo_wr_en(fifo_wr_en),
      .fifo_wr_data(fifo_wr_data), .busy(busy), .frame_done(frame_done), .rd_err(rd_err)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   logic [AW-1:0]  exp_addr_q[$];
   logic [7:0]     exp_len_q[$];
   logic [127:0]   exp_data_q[$];
   logic [127:0]   r_q[$];
   int ar_seen = 0, wr_seen = 0, done_seen = 0, both_cnt = 0;
   int model_os = 0;
   logic ar_hs_f = 1'b0, r_hs_f = 1'b0, both_prev = 1'b0;
   logic [AW-1:0] ar_addr_f;
   logic [7:0]    ar_len_f;
   logic ar_en = 1'b1, r_en = 1'b1, force_rv = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] beat_data(input int idx);
      logic [31:0] w;
      w = 32'hC0DE0000 + 32'(idx);
      return {w, w ^ 32'hFFFF0000, w, w ^ 32'h0000FFFF};
   endfunction

   // Expected burst: start beat index and length in beats.
   task automatic exp_burst(input int beat, input int len);
      exp_addr_q.push_back(AW'(beat * 16));
      exp_len_q.push_back(8'(len - 1));
      for (int i = 0; i < len; i++) exp_data_q.push_back(beat_data(beat + i));
   endtask

   // Monitor: compares handshakes and FIFO writes against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            ar_hs_f = 1'b0; r_hs_f = 1'b0; both_prev = 1'b0; model_os = 0;
         end else begin
            int dec;
            if (both_prev) chk("outstanding_net", 128'(dut.outstanding_r), 128'(model_os));
            ar_hs_f   = axi_arvalid && axi_arready;
            r_hs_f    = axi_rvalid && axi_rready;
            ar_addr_f = axi_araddr;
            ar_len_f  = axi_arlen;
            dec       = (r_hs_f && model_os > 0) ? 1 : 0;
            both_prev = ar_hs_f && (dec == 1);
            if (both_prev) both_cnt++;
            if (ar_hs_f) begin
               ar_seen++;
               if (exp_addr_q.size() == 0) chk("ar_unexpected", 128'(axi_araddr), 128'h1_0000_0000);
               else begin
                  chk("araddr", 128'(axi_araddr), 128'(exp_addr_q.pop_front()));
                  chk("arlen", 128'(axi_arlen), 128'(exp_len_q.pop_front()));
               end
               model_os = model_os + int'(axi_arlen) + 1;
            end
            model_os = model_os - dec;
            if (fifo_wr_en) begin
               wr_seen++;
               if (exp_data_q.size() == 0) chk("wr_unexpected", fifo_wr_data, 128'h0);
               else chk("fifo_data", fifo_wr_data, exp_data_q.pop_front());
            end
            if (frame_done) done_seen++;
         end
      end
   end

   // AXI slave model: accepts ARs when enabled, returns beats in order.
   initial begin
      axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = 128'h0; axi_rlast = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) r_q.delete();
         else begin
            if (r_hs_f && r_q.size() > 0) void'(r_q.pop_front());
            if (ar_hs_f) begin
               for (int i = 0; i <= int'(ar_len_f); i++)
                  r_q.push_back(beat_data(int'(ar_addr_f >> 4) + i));
            end
         end
         axi_arready = ar_en;
         axi_rvalid  = force_rv || (r_en && r_q.size() > 0);
         axi_rdata   = (r_q.size() > 0) ? r_q[0] : 128'h0;
      end
   end

   task automatic start_frame();
      @(posedge clk); #1 frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_reached", 128'(busy), 128'h0);
   endtask

   task automatic wait_arvalid(input int budget);
      int n = 0;
      while (!axi_arvalid && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk("arvalid_seen", 128'(axi_arvalid), 128'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, w0, d0;
      logic [AW-1:0] hold_addr;
      logic [7:0]    hold_len;
      rst = 1'b1; frame_start = 1'b0; wr_water_level = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_arvalid", 128'(axi_arvalid), 128'h0);
      chk("rst_araddr", 128'(axi_araddr), 128'h0);
      chk("rst_arlen", 128'(axi_arlen), 128'h0);
      chk("rst_status", 128'({axi_rready, busy, frame_done, rd_err}), 128'h0);
      rst = 1'b0;

      // 1: full frame, empty FIFO, arready always high, 2-clock issue latency.
      a0 = ar_seen; w0 = wr_seen; d0 = done_seen;
      exp_burst(0, 16); exp_burst(16, 16); exp_burst(32, 8);
      start_frame();
      chk("lat_1clk", 128'(axi_arvalid), 128'h0);
      @(posedge clk); #1;
      chk("lat_2clk", 128'(axi_arvalid), 128'h1);
      wait_idle(500);
      chk("t1_ar_cnt", 128'(ar_seen - a0), 128'd3);
      chk("t1_wr_cnt", 128'(wr_seen - w0), 128'd40);
      chk("t1_done_cnt", 128'(done_seen - d0), 128'd1);

      // 2: not enough room (14 < 16) holds off issue until the level drops.
      a0 = ar_seen; d0 = done_seen;
      exp_burst(0, 16); exp_burst(16, 16); exp_burst(32, 8);
      wr_water_level = 11'd1010;
      start_frame();
      repeat (10) @(posedge clk);
      #1;
      chk("t2_no_ar", 128'({axi_arvalid, 8'(ar_seen - a0)}), 128'h0);
      wr_water_level = 11'd1008;
      @(posedge clk); #1;
      chk("t2_ar_issued", 128'(axi_arvalid), 128'h1);
      wr_water_level = 11'd0;
      wait_idle(500);
      chk("t2_done_cnt", 128'(done_seen - d0), 128'd1);

      // 3: arready held low 5 cycles; request must stay stable.
      a0 = ar_seen;
      exp_burst(0, 16); exp_burst(16, 16); exp_burst(32, 8);
      @(negedge clk) ar_en = 1'b0;
      start_frame();
      wait_arvalid(20);
      hold_addr = axi_araddr; hold_len = axi_arlen;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("t3_stable", 128'({axi_arvalid, axi_araddr, axi_arlen}), 128'({1'b1, hold_addr, hold_len}));
      end
      @(negedge clk) ar_en = 1'b1;
      wait_idle(500);
      chk("t3_ar_cnt", 128'(ar_seen - a0), 128'd3);

      // 4: restart with 32 beats outstanding; drain, then reissue from base.
      a0 = ar_seen; w0 = wr_seen; d0 = done_seen;
      exp_burst(0, 16); exp_burst(16, 16);
      wr_water_level = 11'd985;
      @(negedge clk) r_en = 1'b0;
      start_frame();
      for (int n = 0; n < 50 && (ar_seen - a0) < 2; n++) begin
         @(posedge clk); #1;
      end
      repeat (4) @(posedge clk);
      #1;
      chk("t4_two_ars", 128'({axi_arvalid, 8'(ar_seen - a0)}), 128'h2);
      exp_burst(0, 16); exp_burst(16, 16); exp_burst(32, 8);
      start_frame();
      wr_water_level = 11'd0;
      @(negedge clk) r_en = 1'b1;
      wait_idle(500);
      chk("t4_ar_cnt", 128'(ar_seen - a0), 128'd5);
      chk("t4_wr_cnt", 128'(wr_seen - w0), 128'd72);
      chk("t4_done_cnt", 128'(done_seen - d0), 128'd1);

      // 5: simultaneous AR/R handshakes occurred; stray rvalid sets sticky rd_err.
      chk("t5_simul_seen", 128'(both_cnt > 0), 128'h1);
      chk("t5_err_clear", 128'(rd_err), 128'h0);
      @(negedge clk) force_rv = 1'b1;
      @(negedge clk) force_rv = 1'b0;
      repeat (2) @(negedge clk);
      chk("t5_err_set", 128'(rd_err), 128'h1);
      repeat (6) @(negedge clk);
      chk("t5_err_sticky", 128'({rd_err, fifo_wr_en}), 128'h2);

      // 6: asynchronous reset while a request is waiting for arready.
      @(negedge clk) ar_en = 1'b0;
      start_frame();
      wait_arvalid(20);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t6_async", 128'({axi_arvalid, busy, axi_rready, rd_err}), 128'h0);
      chk("t6_araddr", 128'(axi_araddr), 128'h0);
      exp_addr_q.delete(); exp_len_q.delete(); exp_data_q.delete();
      repeat (2) @(negedge clk);
      ar_en = 1'b1;
      rst = 1'b0;
      d0 = done_seen;
      exp_burst(0, 16); exp_burst(16, 16); exp_burst(32, 8);
      start_frame();
      wait_idle(500);
      chk("t6_recover_done", 128'(done_seen - d0), 128'd1);
      chk("sb_empty", 128'({8'(exp_addr_q.size()), 8'(exp_data_q.size())}), 128'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
